adc_sample_unpacker: RTL and testbench

ADC_SAMPLE_UNPACKER -- requirements
Module: adc_sample_unpacker

---
 rtl/adc_sample_unpacker.sv | 101 ++++++++++
 tb/tb_adc_sample_unpacker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_unpacker.sv
// adc_sample_unpacker: pops 32-bit packed ADC words from a FWFT FIFO and streams
// their three 10-bit samples (low field first) with the word's overrange/trigger flags.
module adc_sample_unpacker #(
    parameter int CNT_W = 32
) (
    input  logic             adc_sampleclk,
    input  logic             ddr_usrreset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic [31:0]      word_data_i,
    input  logic             word_empty_i,
    output logic             word_rd_en_o,
    output logic [9:0]       sample_o,
    output logic             sample_or_o,
    output logic             sample_trig_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] words_done_o
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [31:0]      hold_q, hold_d;
    logic [CNT_W-1:0] total_q, total_d, words_q, words_d;
    // Sequencing: start/abort, word loads, sample phase stepping and word counting
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        hold_d       = hold_q;
        total_d      = total_q;
        words_d      = words_q;
        word_rd_en_o = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                words_d = '0;
                total_d = num_words_i;
                state_d = (num_words_i == '0) ? DONE : LOAD;
            end
            LOAD: if (!start_i) begin
                state_d = IDLE;
                hold_d  = '0;
            end else if (!word_empty_i) begin
                word_rd_en_o = 1'b1;
                hold_d       = word_data_i;
                phase_d      = 2'd0;
                state_d      = EMIT;
            end
            EMIT: if (!start_i) begin
                state_d = IDLE;
                hold_d  = '0;
                phase_d = 2'd0;
            end else if (sample_ready_i) begin
                if (phase_q != 2'd2) begin
                    phase_d = phase_q + 2'd1;
                end else begin
                    words_d = words_q + CNT_W'(1);
                    phase_d = 2'd0;
                    if (words_d == total_q) begin
                        state_d = DONE;
                    end else if (!word_empty_i) begin
                        word_rd_en_o = 1'b1;
                        hold_d       = word_data_i;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: if (!start_i) state_d = IDLE;
        endcase
    end
    // State, phase, holding word and counters
    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            hold_q  <= '0;
            total_q <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            total_q <= total_d;
            words_q <= words_d;
        end
    end
    // Output decode; sample and flags are forced to zero whenever not valid
    always_comb begin
        sample_valid_o = state_q == EMIT;
        sample_o       = !sample_valid_o ? 10'd0 :
                         (phase_q == 2'd0) ? hold_q[9:0] :
                         (phase_q == 2'd1) ? hold_q[19:10] : hold_q[29:20];
        sample_or_o    = sample_valid_o && hold_q[31];
        sample_trig_o  = sample_valid_o && hold_q[30];
        busy_o         = state_q == LOAD || state_q == EMIT;
        done_o         = state_q == DONE;
        words_done_o   = words_q;
    end
endmodule

// File: tb/tb_adc_sample_unpacker.sv
// tb_adc_sample_unpacker: randomized and directed checks against a queue-based model
module tb_adc_sample_unpacker;
    localparam int CNT_W = 32;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] num_words_i = '0;
    logic [31:0]      word_data_i = '0;
    logic             word_empty_i = 1'b1;
    logic             sample_ready_i = 1'b0;
    logic             word_rd_en_o, sample_or_o, sample_trig_o, sample_valid_o, busy_o, done_o;
    logic [9:0]       sample_o;
    logic [CNT_W-1:0] words_done_o;

    adc_sample_unpacker #(.CNT_W(CNT_W)) dut (
        .adc_sampleclk(clk), .ddr_usrreset(rst), .start_i(start_i), .num_words_i(num_words_i),
        .word_data_i(word_data_i), .word_empty_i(word_empty_i), .word_rd_en_o(word_rd_en_o),
        .sample_o(sample_o), .sample_or_o(sample_or_o), .sample_trig_o(sample_trig_o),
        .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i), .busy_o(busy_o),
        .done_o(done_o), .words_done_o(words_done_o)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    logic [31:0] fifo[$];
    logic [11:0] expq[$], got[$];
    int          mode = 0, nm = 0, wdm = 0, ph = 0, pops = 0;
    int          vcnt = 0, first_v = -1, last_v = 0, cyc = 0;
    int          late_cyc = -1;
    logic [31:0] late_word = '0, mw;
    bit          pop_now = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive();
        word_empty_i = fifo.size() == 0;
        word_data_i  = (fifo.size() != 0) ? fifo[0] : $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pop_now && fifo.size() != 0) fifo.delete(0);
        pop_now = 0;
        drive();
    endtask

    // Model: mode 0 idle, 1 running, 2 finished; expq holds samples still owed
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_valid", sample_valid_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_rd_en", word_rd_en_o, 0);
            chk("rst_words_done", words_done_o, 0);
            chk("rst_sample", {sample_or_o, sample_trig_o, sample_o}, 0);
            mode = 0; wdm = 0; ph = 0; pop_now = 0;
            expq.delete();
        end else begin
            pop_now = word_rd_en_o;
            chk("valid", sample_valid_o, expq.size() != 0);
            if (sample_valid_o && expq.size() != 0) begin
                chk("sample", {sample_or_o, sample_trig_o, sample_o}, expq[0]);
                vcnt++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            chk("busy", busy_o, mode == 1);
            chk("done", done_o, mode == 2);
            chk("words_done", words_done_o, wdm);
            if (word_rd_en_o) begin
                chk("pop_legal", !word_empty_i && start_i && mode == 1, 1);
                pops++;
            end
            if (mode == 0) begin
                if (start_i) begin
                    nm = num_words_i; wdm = 0; ph = 0; pops = 0; vcnt = 0; first_v = -1;
                    got.delete();
                    mode = (nm == 0) ? 2 : 1;
                end
            end else if (mode == 1) begin
                if (!start_i) begin
                    mode = 0;
                    expq.delete();
                end else begin
                    if (sample_valid_o && sample_ready_i && expq.size() != 0) begin
                        got.push_back(expq.pop_front());
                        ph++;
                        if (ph == 3) begin ph = 0; wdm++; end
                    end
                    if (word_rd_en_o) begin
                        chk("pop_when_drained", expq.size(), 0);
                        mw = word_data_i;
                        expq.push_back({mw[31:30], mw[9:0]});
                        expq.push_back({mw[31:30], mw[19:10]});
                        expq.push_back({mw[31:30], mw[29:20]});
                    end
                    if (wdm == nm) begin
                        chk("pops_at_done", pops, nm);
                        mode = 2;
                    end
                end
            end else if (!start_i) begin
                mode = 0;
            end
        end
    end

    // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready and num_words churn
    task automatic run(input int n, input int rmode, input int abort_at, input bit rnd);
        bit fin = 0;
        num_words_i = n;
        start_i = 1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            sample_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 4 == 0 || c % 4 == 3) :
                             1'($urandom_range(0, 1));
            if (rnd && $urandom_range(0, 2) == 0) fifo.push_back($urandom);
            if (c == late_cyc) fifo.push_back(late_word);
            if (c > 0 && rmode == 2) num_words_i = $urandom;
            drive();
            tick();
            if (mode == 2) fin = 1;
            if (abort_at > 0 && got.size() >= abort_at) fin = 1;
        end
        chk("run_finished", fin, 1);
        start_i = 0;
        tick();
        tick();
    endtask

    initial begin
        drive();
        repeat (3) tick();
        rst = 0;
        tick();
        chk("idle_after_reset", {busy_o, done_o, sample_valid_o}, 0);
        fifo.push_back(32'h8040_2003);
        drive();
        run(1, 0, 0, 0);
        chk("t1_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("t1_s0", got[0], 12'h803);
            chk("t1_s1", got[1], 12'h808);
            chk("t1_s2", got[2], 12'h804);
        end
        chk("t1_pops", pops, 1);
        chk("t1_words_done", words_done_o, 1);
        chk("t1_valid_run", last_v - first_v, 2);
        repeat (4) fifo.push_back($urandom);
        drive();
        run(4, 0, 0, 0);
        chk("t2_valid_cycles", vcnt, 12);
        chk("t2_no_bubble", last_v - first_v, 11);
        chk("t2_pops", pops, 4);
        chk("t2_words_done", words_done_o, 4);
        repeat (2) fifo.push_back($urandom);
        drive();
        run(2, 1, 0, 0);
        chk("t3_count", got.size(), 6);
        chk("t3_words_done", words_done_o, 2);
        fifo.push_back(32'h1234_5678);
        late_cyc = 8;
        late_word = 32'hC00F_FC01;
        drive();
        run(2, 0, 0, 0);
        late_cyc = -1;
        chk("t4_count", got.size(), 6);
        if (got.size() == 6) chk("t4_w2_s0", got[3], 12'hC01);
        chk("t4_valid_cycles", vcnt, 6);
        chk("t4_gap", last_v - first_v > 5, 1);
        chk("t4_words_done", words_done_o, 2);
        repeat (3) fifo.push_back($urandom);
        drive();
        run(3, 0, 2, 0);
        chk("t5_pops", pops, 1);
        chk("t5_words_done", words_done_o, 0);
        chk("t5_idle", busy_o, 0);
        run(0, 0, 0, 0);
        chk("t5_zero_pops", pops, 0);
        chk("t5_zero_words_done", words_done_o, 0);
        fifo.delete();
        repeat (2) fifo.push_back($urandom);
        drive();
        num_words_i = 2;
        start_i = 1;
        for (int c = 0; c < 50 && got.size() < 1; c++) tick();
        rst = 1;
        start_i = 0;
        tick();
        chk("t6_pops", pops, 1);
        rst = 0;
        tick();
        tick();
        chk("t6_idle", {busy_o, done_o, sample_valid_o}, 0);
        chk("t6_words_done", words_done_o, 0);
        for (int r = 0; r < 30; r++) begin
            int n, ab;
            fifo.delete();
            n  = $urandom_range(1, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 * n - 1) : 0;
            repeat ($urandom_range(0, 3)) fifo.push_back($urandom);
            drive();
            run(n, 2, ab, 1);
            if (ab == 0) chk("rand_words_done", words_done_o, n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
